debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 96 +++++++++
 rtl/debounce_bank.sv | 51 +++++
 tb/tb_debounce_bank.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types for the debounce bank: per-channel FSM state encoding.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } db_state_e;

    // Debounced level implied by a state.
    function automatic logic state_is_high(input db_state_e s);
        return (s == HIGH) || (s == ARM_LO);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single debounce channel: 2-flop synchroniser, stability FSM with tick-gated
// saturating counter, registered level and edge strobes.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             tick,
    input  logic [CNT_W-1:0] db_cycles,
    output logic             debounced,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             debounced_c
);

    logic             sync1_q, sync2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] d_eff;
    logic             debounced_q, debounced_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // A zero threshold would make the ARM states meaningless; treat it as 1.
    assign d_eff   = (db_cycles == '0) ? CNT_W'(1) : db_cycles;
    assign cnt_inc = (tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end
            end
            ARM_HI: begin
                if (!sync2_q)            state_d = IDLE;
                else if (cnt_q >= d_eff) state_d = HIGH;
                else                     cnt_d   = cnt_inc;
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end
            end
            ARM_LO: begin
                if (sync2_q)             state_d = HIGH;
                else if (cnt_q >= d_eff) state_d = IDLE;
                else                     cnt_d   = cnt_inc;
            end
            default: state_d = IDLE;
        endcase
        debounced_d = state_is_high(state_d);
        rise_d      = (state_q == ARM_HI) && (state_d == HIGH);
        fall_d      = (state_q == ARM_LO) && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            debounced_q <= debounced_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
        end
    end

    assign debounced   = debounced_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign debounced_c = debounced_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounce channels with optional input inversion and a
// registered any-active flag aligned with the debounced outputs.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] noisy,
    input  logic                tick,
    input  logic [CNT_W-1:0]    db_cycles,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_active
);

    logic [CHANNELS-1:0] noisy_in;
    logic [CHANNELS-1:0] debounced_c;
    logic                any_active_q, any_active_d;

    assign noisy_in = (ACTIVE_LOW != 0) ? ~noisy : noisy;

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
        debounce_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .din         (noisy_in[i]),
            .tick        (tick),
            .db_cycles   (db_cycles),
            .debounced   (debounced[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .debounced_c (debounced_c[i])
        );
    end

    // Built from next-state levels so it changes in the same cycle as debounced.
    assign any_active_d = |debounced_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) any_active_q <= 1'b0;
        else     any_active_q <= any_active_d;
    end

    assign any_active = any_active_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a level/pending model.
module tb_debounce_bank;

    localparam int unsigned NCH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  noisy0, noisy1;
    logic            tick;
    logic [19:0]     db;
    logic [2:0]      db1;
    logic [NCH-1:0]  deb0, rise0, fall0, deb1, rise1, fall1;
    logic            any0, any1;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int tick_mode = 0;

    // model state, index [dut][channel]
    bit sy1[2][NCH], sy2[2][NCH], lvl[2][NCH], pend[2][NCH];
    bit rp[2][NCH], fp[2][NCH];
    int cnt[2][NCH];

    assign db1 = db[2:0];

    always #5 clk = ~clk;

    debounce_bank #(.CHANNELS(NCH), .CNT_W(20), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst(rst), .noisy(noisy0), .tick(tick), .db_cycles(db),
        .debounced(deb0), .rise_pulse(rise0), .fall_pulse(fall0), .any_active(any0)
    );

    debounce_bank #(.CHANNELS(NCH), .CNT_W(3), .ACTIVE_LOW(1)) dut1 (
        .clk(clk), .rst(rst), .noisy(noisy1), .tick(tick), .db_cycles(db1),
        .debounced(deb1), .rise_pulse(rise1), .fall_pulse(fall1), .any_active(any1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs seen at the edge.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < int'(NCH); i++) begin
                int deff, cmax;
                bit a, s;
                rp[m][i] = 1'b0;
                fp[m][i] = 1'b0;
                if (rst) begin
                    sy1[m][i] = 0; sy2[m][i] = 0; lvl[m][i] = 0; pend[m][i] = 0; cnt[m][i] = 0;
                end else begin
                    a    = (m == 0) ? noisy0[i] : !noisy1[i];
                    deff = (m == 0) ? int'(db) : int'(db1);
                    if (deff == 0) deff = 1;
                    cmax = (m == 0) ? (1 << 20) - 1 : 7;
                    s = sy2[m][i];
                    if (s != lvl[m][i]) begin
                        if (!pend[m][i]) begin
                            pend[m][i] = 1; cnt[m][i] = 0;
                        end else if (cnt[m][i] >= deff) begin
                            lvl[m][i] = s; pend[m][i] = 0;
                            rp[m][i] = s; fp[m][i] = !s;
                        end else if (tick && cnt[m][i] < cmax) begin
                            cnt[m][i]++;
                        end
                    end else begin
                        pend[m][i] = 0;
                    end
                    sy2[m][i] = sy1[m][i];
                    sy1[m][i] = a;
                end
            end
        end
    endtask

    task automatic step();
        logic [NCH-1:0] el[2], er[2], ef[2];
        @(posedge clk);
        model_edge();
        #1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < int'(NCH); i++) begin
                el[m][i] = lvl[m][i]; er[m][i] = rp[m][i]; ef[m][i] = fp[m][i];
            end
        check("deb0",  32'(deb0),  32'(el[0]));
        check("rise0", 32'(rise0), 32'(er[0]));
        check("fall0", 32'(fall0), 32'(ef[0]));
        check("any0",  32'(any0),  32'(|el[0]));
        check("deb1",  32'(deb1),  32'(el[1]));
        check("rise1", 32'(rise1), 32'(er[1]));
        check("fall1", 32'(fall1), 32'(ef[1]));
        check("any1",  32'(any1),  32'(|el[1]));
        cyc++;
        case (tick_mode)
            0:       tick = 1'b1;
            1:       tick = ((cyc % 4) == 3);
            default: tick = 1'(($urandom % 3) == 0);
        endcase
    endtask

    task automatic set_ch(input int i, input bit v);
        noisy0[i] = v;
        noisy1[i] = !v;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; db = 20'd3;
        noisy0 = '0; noisy1 = '1;
        run(3);
        check("rst_deb0", 32'(deb0), 32'd0);
        check("rst_any1", 32'(any1), 32'd0);
        rst = 1'b0;
        run(4);

        // clean rise on ch0 with D=3: level and strobe after edge 6 only
        set_ch(0, 1);
        for (int k = 0; k <= 8; k++) begin
            step();
            if (k == 5) check("d36_early", 32'(deb0[0]), 32'd0);
            if (k == 6) begin
                check("d36_deb",  32'(deb0[0]),  32'd1);
                check("d36_rise", 32'(rise0[0]), 32'd1);
                check("d36_rise_al", 32'(rise1[0]), 32'd1);
            end
            if (k == 7) check("d36_rise_off", 32'(rise0[0]), 32'd0);
        end

        // ch1 short pulse, ch0 short low glitch
        set_ch(1, 1); run(2); set_ch(1, 0); run(10);
        set_ch(0, 0); run(2); set_ch(0, 1); run(10);
        check("glitch_hold", 32'(deb0[0]), 32'd1);

        // ch0 held low: fall strobe after edge 6
        set_ch(0, 0);
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 6) check("d39_fall", 32'(fall0[0]), 32'd1);
            if (k == 7) check("d39_fall_off", 32'(fall0[0]), 32'd0);
        end

        // sparse tick, D=2, ch2
        tick_mode = 1; db = 20'd2;
        set_ch(2, 1); run(24); set_ch(2, 0); run(24);
        tick_mode = 0; db = 20'd3;
        run(2);

        // all channels together
        for (int i = 0; i < int'(NCH); i++) set_ch(i, 1);
        for (int k = 0; k <= 6; k++) step();
        check("all_rise", 32'(rise0), 32'hf);
        run(3);

        // reset while HIGH, then re-arm
        for (int i = 0; i < 3; i++) set_ch(i, 0);
        run(10);
        rst = 1'b1; run(3); rst = 1'b0;
        check("rst_fall", 32'(fall0), 32'd0);
        run(10);

        // zero threshold behaves as 1
        db = 20'd0;
        set_ch(3, 0); run(8); set_ch(3, 1); run(8); set_ch(1, 1); run(2); set_ch(1, 0); run(8);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            if ((k % 150) == 0) tick_mode = int'($urandom_range(0, 2));
            if (($urandom % 40) == 0) db = 20'($urandom_range(0, 5));
            if (($urandom % 6) == 0) set_ch(int'($urandom_range(0, NCH - 1)), 1'($urandom));
            if (($urandom % 400) == 0) rst = 1'b1;
            else rst = 1'b0;
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
